// File: rtl/imm_pkg.sv
// imm_pkg -- shared definitions for the immediate-extend stage.
//   INSTR_W    : width of a raw RV32 instruction word
//   IMM_SRC_W  : width of the immediate format select
//   imm_src_e  : immediate format encodings (I, S, B, U, J); 101..111 are unsupported
//   imm_src_supported() : true for the five defined encodings
package imm_pkg;

    localparam int INSTR_W   = 32;
    localparam int IMM_SRC_W = 3;

    typedef enum logic [IMM_SRC_W-1:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_e;

    function automatic logic imm_src_supported(input logic [IMM_SRC_W-1:0] src);
        return (src <= IMM_J);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode -- combinational immediate decode and sign extension.
//   instr   : raw RV32 instruction word
//   imm_src : immediate format select (imm_src_e encodings)
//   imm     : immediate sign-extended from instr[31] to DATA_BUS_WIDTH
//   imm_err : high for an unsupported imm_src; imm is forced to zero then
module imm_decode
    import imm_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 32
) (
    input  logic [INSTR_W-1:0]        instr,
    input  logic [IMM_SRC_W-1:0]      imm_src,
    output logic [DATA_BUS_WIDTH-1:0] imm,
    output logic                      imm_err
);

    // Every format is first built as a 32-bit sign-extended value; the final
    // widening to 64 bits then copies bit 31, which is instr[31] for all
    // formats (U-type included).
    logic [INSTR_W-1:0] imm32;

    always_comb begin
        imm32   = '0;
        imm_err = 1'b0;
        case (imm_src)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: begin
                imm32   = '0;
                imm_err = 1'b1;
            end
        endcase
    end

    assign imm = DATA_BUS_WIDTH'($signed(imm32));

endmodule

// File: rtl/imm_extend_stage.sv
// imm_extend_stage -- decodes/sign-extends an instruction immediate and holds
// the results in a small circular output buffer.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   in_valid      : upstream instruction valid
//   in_ready      : stage accepts an input this cycle
//   instr         : raw RV32 instruction word
//   imm_src       : immediate format select
//   out_valid     : head entry valid
//   out_ready     : downstream accepts the head entry
//   extended_imm  : head-entry immediate (zero when no valid head)
//   imm_err       : head entry carried an unsupported imm_src
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high on that side; valid never depends on ready of the same side. A push and
// a pop may happen on the same edge, leaving the occupancy unchanged. in_ready
// is combinationally raised by out_ready when the buffer is full so that a
// full buffer can stream at one entry per cycle. While rst is high both
// in_ready and out_valid are held low, so nothing transfers in a reset cycle.
module imm_extend_stage
    import imm_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 32,
    parameter int BUF_DEPTH      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INSTR_W-1:0]        instr,
    input  logic [IMM_SRC_W-1:0]      imm_src,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_BUS_WIDTH-1:0] extended_imm,
    output logic                      imm_err
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_BUS_WIDTH-1:0] imm_mem [BUF_DEPTH];
    logic                      err_mem [BUF_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [DATA_BUS_WIDTH-1:0] dec_imm;
    logic                      dec_err;
    logic                      push;
    logic                      pop;

    imm_decode #(
        .DATA_BUS_WIDTH(DATA_BUS_WIDTH)
    ) u_decode (
        .instr   (instr),
        .imm_src (imm_src),
        .imm     (dec_imm),
        .imm_err (dec_err)
    );

    assign out_valid = !rst && (count != '0);
    assign in_ready  = !rst && ((count < DEPTH_CNT) || out_ready);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage is not reset: validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            imm_mem[wr_ptr] <= dec_imm;
            err_mem[wr_ptr] <= dec_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Outputs read as zero whenever there is no valid head entry.
    assign extended_imm = out_valid ? imm_mem[rd_ptr] : '0;
    assign imm_err      = out_valid && err_mem[rd_ptr];

endmodule

// File: tb/tb_imm_extend_stage.sv
module tb_imm_extend_stage;

    localparam int A_DEPTH = 2;
    localparam int B_DEPTH = 3;
    localparam int NV      = 11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // DUT A: 32-bit, depth 2
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err;
    logic [31:0] a_instr, a_ext;
    logic [2:0]  a_src;
    // DUT B: 64-bit, depth 3
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
    logic [31:0] b_instr;
    logic [63:0] b_ext;
    logic [2:0]  b_src;

    imm_extend_stage #(.DATA_BUS_WIDTH(32), .BUF_DEPTH(A_DEPTH)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .instr(a_instr), .imm_src(a_src),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .extended_imm(a_ext), .imm_err(a_err)
    );

    imm_extend_stage #(.DATA_BUS_WIDTH(64), .BUF_DEPTH(B_DEPTH)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .instr(b_instr), .imm_src(b_src),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .extended_imm(b_ext), .imm_err(b_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit sb_on    = 1'b0;

    // ---------------- reference model ----------------
    function automatic longint sx(input longint v, input int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    // Returns {err, imm64}: immediate value built from the ISA field layout.
    function automatic logic [64:0] ref_imm(input logic [31:0] ins, input logic [2:0] src);
        longint u;
        longint v;
        u = longint'(ins);
        v = 0;
        case (src)
            3'd0: v = sx(u >> 20, 12);
            3'd1: v = sx(((u >> 25) << 5) + ((u >> 7) & 64'd31), 12);
            3'd2: v = sx((((u >> 31) & 64'd1) << 12) + (((u >> 7) & 64'd1) << 11)
                         + (((u >> 25) & 64'd63) << 5) + (((u >> 8) & 64'd15) << 1), 13);
            3'd3: v = sx(u & 64'hFFFF_F000, 32);
            3'd4: v = sx((((u >> 31) & 64'd1) << 20) + (((u >> 12) & 64'd255) << 12)
                         + (((u >> 20) & 64'd1) << 11) + (((u >> 21) & 64'd1023) << 1), 21);
            default: return {1'b1, 64'd0};
        endcase
        return {1'b0, 64'(v)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboards ----------------
    logic [64:0] exp_a[$];
    logic [64:0] exp_b[$];
    logic        a_exp_v, a_exp_r, b_exp_v, b_exp_r;
    logic [64:0] a_head, b_head;

    always @(negedge clk) begin
        if (sb_on) begin
            a_exp_v = !rst && (exp_a.size() != 0);
            a_exp_r = !rst && ((exp_a.size() < A_DEPTH) || a_out_ready);
            a_head  = a_exp_v ? exp_a[0] : 65'd0;
            check("sb_a_out_valid", 64'(a_out_valid), 64'(a_exp_v));
            check("sb_a_in_ready", 64'(a_in_ready), 64'(a_exp_r));
            check("sb_a_imm", {32'd0, a_ext}, {32'd0, a_head[31:0]});
            check("sb_a_err", 64'(a_err), 64'(a_head[64]));
            if (rst) exp_a.delete();
            else begin
                if (a_exp_v && a_out_ready) void'(exp_a.pop_front());
                if (a_in_valid && a_exp_r) exp_a.push_back(ref_imm(a_instr, a_src));
            end

            b_exp_v = !rst && (exp_b.size() != 0);
            b_exp_r = !rst && ((exp_b.size() < B_DEPTH) || b_out_ready);
            b_head  = b_exp_v ? exp_b[0] : 65'd0;
            check("sb_b_out_valid", 64'(b_out_valid), 64'(b_exp_v));
            check("sb_b_in_ready", 64'(b_in_ready), 64'(b_exp_r));
            check("sb_b_imm", b_ext, b_head[63:0]);
            check("sb_b_err", 64'(b_err), 64'(b_head[64]));
            if (rst) exp_b.delete();
            else begin
                if (b_exp_v && b_out_ready) void'(exp_b.pop_front());
                if (b_in_valid && b_exp_r) exp_b.push_back(ref_imm(b_instr, b_src));
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        err;
    } vec_t;

    vec_t vecs[NV];

    // ---------------- test sequence ----------------
    initial begin
        vecs[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
        vecs[1]  = '{32'h0020A423, 3'd1, 32'h00000008, 64'h00000000_00000008, 1'b0};
        vecs[2]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
        vecs[3]  = '{32'h123450B7, 3'd3, 32'h12345000, 64'h00000000_12345000, 1'b0};
        vecs[4]  = '{32'h0010006F, 3'd4, 32'h00000800, 64'h00000000_00000800, 1'b0};
        vecs[5]  = '{32'h800000B7, 3'd3, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0};
        vecs[6]  = '{32'hDEADBEEF, 3'd7, 32'h00000000, 64'h00000000_00000000, 1'b1};
        vecs[7]  = '{32'h00500013, 3'd0, 32'h00000005, 64'h00000000_00000005, 1'b0};
        vecs[8]  = '{32'hFE112E23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
        vecs[9]  = '{32'hFFDFF06F, 3'd4, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
        vecs[10] = '{32'hFFF00093, 3'd5, 32'h00000000, 64'h00000000_00000000, 1'b1};

        rst = 1'b1;
        a_in_valid = 1'b0; a_instr = '0; a_src = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_instr = '0; b_src = '0; b_out_ready = 1'b0;
        repeat (3) tick();
        rst   = 1'b0;
        sb_on = 1'b1;

        // Post-reset state
        #1;
        check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_imm", {32'd0, a_ext}, 64'd0);
        check("rst_a_err", 64'(a_err), 64'd0);
        check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        check("rst_b_imm", b_ext, 64'd0);

        // Back-to-back table vectors: each visible one cycle after its push
        a_out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            a_in_valid = 1'b1; a_instr = vecs[i].instr; a_src = vecs[i].src;
            tick();
            check($sformatf("vec_a%0d_valid", i), 64'(a_out_valid), 64'd1);
            check($sformatf("vec_a%0d_imm", i), {32'd0, a_ext}, {32'd0, vecs[i].e32});
            check($sformatf("vec_a%0d_err", i), 64'(a_err), 64'(vecs[i].err));
        end
        a_in_valid = 1'b0;
        tick();
        check("vec_a_drained", 64'(a_out_valid), 64'd0);

        b_out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            b_in_valid = 1'b1; b_instr = vecs[i].instr; b_src = vecs[i].src;
            tick();
            check($sformatf("vec_b%0d_valid", i), 64'(b_out_valid), 64'd1);
            check($sformatf("vec_b%0d_imm", i), b_ext, vecs[i].e64);
            check($sformatf("vec_b%0d_err", i), 64'(b_err), 64'(vecs[i].err));
        end
        b_in_valid = 1'b0;
        tick();
        check("vec_b_drained", 64'(b_out_valid), 64'd0);

        // Full buffer backpressure on depth-2 stage
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_instr = 32'hFFF00093; a_src = 3'd0;
        #1 check("bp_first_ready", 64'(a_in_ready), 64'd1);
        tick();
        a_instr = 32'h0020A423; a_src = 3'd1;
        tick();
        a_instr = 32'h123450B7; a_src = 3'd3;
        #1 check("bp_full_ready", 64'(a_in_ready), 64'd0);
        tick();
        check("bp_hold_valid", 64'(a_out_valid), 64'd1);
        check("bp_hold_imm", {32'd0, a_ext}, 64'hFFFFFFFF);
        a_out_ready = 1'b1;
        #1 check("bp_full_pop_ready", 64'(a_in_ready), 64'd1);
        tick();
        a_in_valid = 1'b0;
        check("bp_second", {32'd0, a_ext}, 64'h00000008);
        tick();
        check("bp_third", {32'd0, a_ext}, 64'h12345000);
        tick();
        check("bp_empty", 64'(a_out_valid), 64'd0);

        // Reset with two entries buffered
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_instr = 32'hFFF00093; a_src = 3'd0;
        tick();
        a_instr = 32'h00500013;
        tick();
        check("mid_rst_full", 64'(a_in_ready), 64'd0);
        rst = 1'b1; a_out_ready = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(a_in_ready), 64'd0);
        tick();
        rst = 1'b0; a_in_valid = 1'b0;
        #1;
        check("after_rst_in_ready", 64'(a_in_ready), 64'd1);
        check("after_rst_out_valid", 64'(a_out_valid), 64'd0);
        check("after_rst_imm", {32'd0, a_ext}, 64'd0);

        // Randomized traffic, checked by the scoreboards
        for (int c = 0; c < 800; c++) begin
            rst         = ($urandom_range(0, 63) == 0);
            a_in_valid  = ($urandom_range(0, 9) < 7);
            a_instr     = $urandom;
            a_src       = 3'($urandom_range(0, 7));
            a_out_ready = ($urandom_range(0, 9) < 5);
            b_in_valid  = ($urandom_range(0, 9) < 6);
            b_instr     = $urandom;
            b_src       = 3'($urandom_range(0, 7));
            b_out_ready = ($urandom_range(0, 9) < 4);
            tick();
        end
        rst = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        repeat (5) tick();
        check("final_a_empty", 64'(a_out_valid), 64'd0);
        check("final_b_empty", 64'(b_out_valid), 64'd0);

        sb_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
